io_input_debounce: RTL and testbench
====================================

// Module: io_input_debounce
// PURPOSE
//  Conditions the raw board switch and push-button pins before they reach the
//  core's i_io_sw / i_io_btn inputs: 2-flop synchronisation, tick-based debounce
//  and one-cycle press/release pulses per button. Sits directly upstream of the
//  single-cycle core at board top level; outputs connect straight to its inputs.
// PARAMETERS
//  SW_W           32     number of slide switches
//  BTN_W          4      number of push buttons
//  TICK_CYCLES    50000  clk cycles per sample tick (1 ms @ 50 MHz), >=2
//  STABLE_TICKS   4      consecutive disagreeing ticks needed to accept new level, >=1
//  BTN_ACTIVE_LOW 1      1: raw button pin 0 = pressed; 0: raw 1 = pressed
// PORTS
//  i_clk          in   1      system clock
//  i_rst_n        in   1      reset, asynchronous, active-low
//  i_sw_raw       in   SW_W   asynchronous switch pins, 1 = up
//  i_btn_raw      in   BTN_W  asynchronous button pins, polarity per BTN_ACTIVE_LOW
//  o_io_sw        out  SW_W   debounced switches, 1 = up (to core i_io_sw)
//  o_io_btn       out  BTN_W  debounced buttons, always 1 = pressed (to core i_io_btn)
//  o_btn_press    out  BTN_W  1-cycle pulse when o_io_btn bit goes 0->1
//  o_btn_release  out  BTN_W  1-cycle pulse when o_io_btn bit goes 1->0
// BEHAVIOUR
//  Reset (async assert, sync deassert by board): all outputs 0; tick counter 0;
//   all stable counters 0; sync flops reset to inactive level (sw 0, btn "released").
//  Sync: 2 flops per bit; button polarity normalised after sync (pressed = 1).
//  Tick: free-running counter 0..TICK_CYCLES-1, wraps; tick=1 for the one cycle
//   the count equals TICK_CYCLES-1. Shared by all bits.
//  Per bit (switches and buttons identical), registers: level L (= output), cnt:
//   - synced == L, any cycle: cnt <= 0 (glitch cancels progress immediately).
//   - synced != L, tick, cnt <  STABLE_TICKS-1: cnt <= cnt+1.
//   - synced != L, tick, cnt == STABLE_TICKS-1: L <= synced, cnt <= 0.
//   - otherwise hold. cnt width = $clog2(STABLE_TICKS)+1, never wraps.
//  Latency raw->output: 2 sync cycles + STABLE_TICKS ticks; range
//   [2+(STABLE_TICKS-1)*TICK_CYCLES+1, 2+STABLE_TICKS*TICK_CYCLES] cycles.
//  Pulses: registered alongside L from same next-state; o_btn_press[i] high exactly
//   in the cycle o_io_btn[i] first reads 1, low otherwise; release likewise. Press
//   and release of the same bit never coincide; different bits independent.
//  Button held through reset release: normal debounce, press pulse fires once.
//  No spurious pulses at reset release when pins are at inactive level.
//  Reset mid-debounce: progress lost, outputs 0 immediately, restart from scratch.
//  STABLE_TICKS=1: first tick seeing disagreement updates L.
// TESTING  (TICK_CYCLES=4, STABLE_TICKS=3, BTN_ACTIVE_LOW=1)
//  1 Reset, pins idle (sw=0, btn=4'hF) for 50 cycles -> all outputs 0, no pulses.
//  2 btn_raw[0] 1->0 and held -> o_io_btn[0]=1 11..14 cycles later, o_btn_press
//    =4'b0001 for exactly that cycle; release -> o_btn_release[0] 1 cycle.
//  3 btn_raw[1] low for 5 cycles then high, repeated bounce -> o_io_btn stays 0,
//    no pulses.
//  4 i_sw_raw 0 -> 32'hA5A5_0F0F -> o_io_sw equals it after 11..14 cycles, all
//    bits same cycle; no button pulses.
//  5 Hold btn_raw[2]=0, assert i_rst_n=0 mid-debounce (after 6 cycles) for 3
//    cycles -> outputs 0 asynchronously; after release press takes full 11..14 cyc.
//  6 btn_raw[0] pressed while btn_raw[3] released, same cycle -> press[0] and
//    release[3] both pulse in the same cycle.

Source files
------------

// File: rtl/io_input_debounce.sv
// io_input_debounce: conditions raw board switch and push-button pins before
// they reach the core. Each pin is synchronised through two flops, button
// polarity is normalised so that 1 always means pressed, and every bit is then
// debounced against a shared sample tick. Buttons also produce one-cycle press
// and release pulses that are aligned with the debounced level.
module io_input_debounce #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int TICK_CYCLES    = 50000,
  parameter int STABLE_TICKS   = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic [BTN_W-1:0] o_btn_release
);

  // Switches occupy the low bits of the combined vector and buttons the high
  // bits, so one debounce loop can serve every bit.
  localparam int N  = SW_W + BTN_W;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = $clog2(STABLE_TICKS) + 1;

  // A released button sits at logic 1 on the pin when it is active-low.
  localparam logic [BTN_W-1:0] BTN_IDLE = {BTN_W{BTN_ACTIVE_LOW}};

  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [BTN_W-1:0] btn_meta;
  logic [BTN_W-1:0] btn_sync;
  logic [BTN_W-1:0] btn_norm;
  logic [N-1:0]     synced;

  logic [TW-1:0]    tick_cnt;
  logic             tick;

  logic [N-1:0]     level_q;
  logic [N-1:0]     level_d;
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];

  logic [BTN_W-1:0] press_q;
  logic [BTN_W-1:0] release_q;

  // Two-flop synchronisers, reset to the inactive pin level so that no
  // disagreement is seen when reset releases with the pins idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= BTN_IDLE;
      btn_sync <= BTN_IDLE;
    end else begin
      sw_meta  <= i_sw_raw;
      sw_sync  <= sw_meta;
      btn_meta <= i_btn_raw;
      btn_sync <= btn_meta;
    end
  end

  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;
  assign synced   = {btn_norm, sw_sync};

  // Free-running sample-tick counter shared by every bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

  // Per-bit debounce: any agreement clears progress, and each tick that sees
  // disagreement advances it until the new level is accepted.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (synced[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
          level_d[i] = synced[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels, counters and edge pulses all update from the same
  // next-state, so a pulse lines up with the first cycle of its new level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= level_d[N-1:SW_W] & ~level_q[N-1:SW_W];
      release_q <= ~level_d[N-1:SW_W] & level_q[N-1:SW_W];
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_io_sw       = level_q[SW_W-1:0];
  assign o_io_btn      = level_q[N-1:SW_W];
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;

endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed stimulus for io_input_debounce with a
// scoreboard. Stimulus pushes each expected output event together with its
// allowed cycle window; a monitor pops and compares whenever the outputs
// change level or a pulse is present.
module tb_io_input_debounce;

  localparam int SW_W         = 32;
  localparam int BTN_W        = 4;
  localparam int TICK_CYCLES  = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * TICK_CYCLES + 1;
  localparam int LAT_MAX      = 2 + STABLE_TICKS * TICK_CYCLES;

  typedef struct {
    logic [SW_W-1:0]  sw;
    logic [BTN_W-1:0] btn;
    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] rel;
    int               min_c;
    int               max_c;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [SW_W-1:0]  sw_raw;
  logic [BTN_W-1:0] btn_raw;
  logic [SW_W-1:0]  io_sw;
  logic [BTN_W-1:0] io_btn;
  logic [BTN_W-1:0] btn_press;
  logic [BTN_W-1:0] btn_release;

  exp_t             exp_q [$];
  int               cyc    = 0;
  int               checks = 0;
  int               errors = 0;
  logic [SW_W-1:0]  prev_sw  = '0;
  logic [BTN_W-1:0] prev_btn = '0;

  io_input_debounce #(
    .SW_W          (SW_W),
    .BTN_W         (BTN_W),
    .TICK_CYCLES   (TICK_CYCLES),
    .STABLE_TICKS  (STABLE_TICKS),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sw_raw     (sw_raw),
    .i_btn_raw    (btn_raw),
    .o_io_sw      (io_sw),
    .o_io_btn     (io_btn),
    .o_btn_press  (btn_press),
    .o_btn_release(btn_release)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so events can be placed in cycle windows.
  always @(posedge clk) cyc++;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of stimulus, expected finish before limit");
    $fatal(1, "[TB] timeout");
  end

  // Direct comparison used for reset and asynchronous-clear checks.
  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Queue an expected output event allowed between LAT_MIN and LAT_MAX cycles
  // after the current cycle.
  task automatic apply_stimulus(input logic [SW_W-1:0] sw, input logic [BTN_W-1:0] btn,
                                input logic [BTN_W-1:0] press, input logic [BTN_W-1:0] rel);
    exp_t e;
    e.sw    = sw;
    e.btn   = btn;
    e.press = press;
    e.rel   = rel;
    e.min_c = cyc + LAT_MIN;
    e.max_c = cyc + LAT_MAX;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any level change or pulse is an output event to be matched.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_sw  = '0;
      prev_btn = '0;
    end else if (io_sw !== prev_sw || io_btn !== prev_btn || |btn_press || |btn_release) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got sw=%h btn=%b press=%b release=%b at cycle %0d, expected no event",
                 io_sw, io_btn, btn_press, btn_release, cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (io_sw !== e.sw || io_btn !== e.btn || btn_press !== e.press || btn_release !== e.rel) begin
          errors++;
          $display("[TB] FAIL event_value: got sw=%h btn=%b press=%b release=%b, expected sw=%h btn=%b press=%b release=%b",
                   io_sw, io_btn, btn_press, btn_release, e.sw, e.btn, e.press, e.rel);
        end
        checks++;
        if (cyc < e.min_c || cyc > e.max_c) begin
          errors++;
          $display("[TB] FAIL event_time: got cycle %0d, expected cycle in [%0d,%0d]", cyc, e.min_c, e.max_c);
        end
      end
      prev_sw  = io_sw;
      prev_btn = io_btn;
    end
  end

  initial begin
    rst_n   = 1'b0;
    sw_raw  = '0;
    btn_raw = 4'hF;
    wait_cycles(3);
    check_output("reset_sw", 64'(io_sw), 64'h0);
    check_output("reset_btn", 64'(io_btn), 64'h0);
    check_output("reset_press", 64'(btn_press), 64'h0);
    check_output("reset_release", 64'(btn_release), 64'h0);
    rst_n = 1'b1;

    // Idle pins after reset: no events at all.
    wait_cycles(50);
    check_output("idle_sw", 64'(io_sw), 64'h0);
    check_output("idle_btn", 64'(io_btn), 64'h0);

    // Press and release button 0.
    btn_raw = 4'hE;
    apply_stimulus('0, 4'b0001, 4'b0001, 4'b0000);
    wait_cycles(20);
    btn_raw = 4'hF;
    apply_stimulus('0, 4'b0000, 4'b0000, 4'b0001);
    wait_cycles(20);

    // Bouncing button 1 never stays low for three ticks.
    for (int k = 0; k < 4; k++) begin
      btn_raw[1] = 1'b0;
      wait_cycles(5);
      btn_raw[1] = 1'b1;
      wait_cycles(3);
    end
    wait_cycles(20);

    // Switch pattern arrives on all bits in one cycle.
    sw_raw = 32'hA5A5_0F0F;
    apply_stimulus(32'hA5A5_0F0F, 4'b0000, 4'b0000, 4'b0000);
    wait_cycles(20);

    // Reset part way through a button 2 debounce clears everything at once.
    btn_raw[2] = 1'b0;
    wait_cycles(6);
    rst_n = 1'b0;
    #1;
    check_output("async_sw", 64'(io_sw), 64'h0);
    check_output("async_btn", 64'(io_btn), 64'h0);
    check_output("async_press", 64'(btn_press), 64'h0);
    check_output("async_release", 64'(btn_release), 64'h0);
    wait_cycles(3);
    rst_n = 1'b1;
    apply_stimulus(32'hA5A5_0F0F, 4'b0100, 4'b0100, 4'b0000);
    wait_cycles(20);
    btn_raw[2] = 1'b1;
    apply_stimulus(32'hA5A5_0F0F, 4'b0000, 4'b0000, 4'b0100);
    wait_cycles(20);

    // Press button 3, then swap it for button 0 in a single cycle.
    btn_raw[3] = 1'b0;
    apply_stimulus(32'hA5A5_0F0F, 4'b1000, 4'b1000, 4'b0000);
    wait_cycles(20);
    btn_raw = 4'b1110;
    apply_stimulus(32'hA5A5_0F0F, 4'b0001, 4'b0001, 4'b1000);
    wait_cycles(20);

    // Anything still queued never showed up.
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event: got nothing, expected sw=%h btn=%b press=%b release=%b by cycle %0d",
               e.sw, e.btn, e.press, e.rel, e.max_c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
